// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub result buffer slice.
package addsub_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } buf_state_t;

  localparam int unsigned FLG_OVF  = 3;
  localparam int unsigned FLG_NEG  = 2;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_M    = 0;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/addsub_flag_gen.sv
// Push-path entry formatting: optional saturation and {ovf, neg, zero, m} flags.
// Saturation is compiled in only when ADDSUB_SAT_EN is defined.
module addsub_flag_gen #(
  parameter int unsigned DATA_W = addsub_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] answer,
  input  logic              ovf,
  input  logic              m,
  output logic [DATA_W-1:0] stored,
  output logic [3:0]        flags
);
  import addsub_pkg::*;

  always_comb begin
    stored = answer;
`ifdef ADDSUB_SAT_EN
    // A wrapped result with the sign bit set came from a positive overflow.
    if (ovf) begin
      stored = answer[DATA_W-1] ? DATA_W'(SAT_POS) : DATA_W'(SAT_NEG);
    end
`endif
    flags           = '0;
    flags[FLG_OVF]  = ovf;
    flags[FLG_NEG]  = stored[DATA_W-1];
    flags[FLG_ZERO] = (stored == '0);
    flags[FLG_M]    = m;
  end

endmodule

// File: rtl/addsub_result_buffer.sv
// Result FIFO behind the add/sub unit with status flags and a sticky overflow bit.
// Optional saturation on push is enabled by defining ADDSUB_SAT_EN.
module addsub_result_buffer #(
  parameter int unsigned DATA_W = addsub_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_answer,
  input  logic              in_ovf,
  input  logic              in_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_answer,
  output logic [3:0]        out_flags,
  output logic [PTR_W:0]    count,
  output logic              sticky_ovf,
  input  logic              clr_sticky
);
  import addsub_pkg::*;

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH - 1);

  buf_state_t state, state_nxt;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_answer [DEPTH];
  logic [3:0]        mem_flags  [DEPTH];
  logic [DATA_W-1:0] new_answer;
  logic [3:0]        new_flags;
  logic              push, pop;

  addsub_flag_gen #(
    .DATA_W(DATA_W)
  ) u_flag_gen (
    .answer(in_answer),
    .ovf   (in_ovf),
    .m     (in_m),
    .stored(new_answer),
    .flags (new_flags)
  );

  assign in_ready   = (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_answer = mem_answer[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:  if (push) state_nxt = ACTIVE;
      ACTIVE: begin
        if (push && !pop && count == CNT_LAST)     state_nxt = FULL;
        else if (pop && !push && count == CNT_ONE) state_nxt = EMPTY;
      end
      FULL:   if (pop) state_nxt = ACTIVE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Storage is cleared on reset so the combinational read port shows zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_answer[i] <= '0;
        mem_flags[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_answer[wr_ptr] <= new_answer;
        mem_flags[wr_ptr]  <= new_flags;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // An overflowing push in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (push && new_flags[FLG_OVF]) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end

endmodule
